// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one data_memory between the CPU load/store unit (port 0)
// and the loader/debug port (port 1). One memory access cycle per transaction, registered ack.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_any;
  logic              grant_sel;

  // On a tie, round-robin hands the grant to the port that did not win last time.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = 1'b0;
    if (req0 && req1) begin
      grant_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      grant_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (grant_any) begin
            sel        <= grant_sel;
            last_grant <= grant_sel;
            we_q       <= grant_sel ? we1    : we0;
            addr_q     <= grant_sel ? addr1  : addr0;
            wdata_q    <= grant_sel ? wdata1 : wdata0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (sel) rdata1 <= read_data;
            else     rdata0 <= read_data;
          end
          ack0  <= ~sel;
          ack1  <= sel;
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst_n so a reset landing mid-ACCESS never commits a write.
  assign mem_write  = rst_n & (state == ACCESS) & we_q;
  assign mem_read   = rst_n & (state == ACCESS) & ~we_q;
  assign endereco   = addr_q;
  assign write_data = wdata_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance on a modelled data_memory,
// plus a fixed-priority instance for the tie-break check.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clear;

  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_read, mem_write, busy;
  logic [31:0] rdata0, rdata1, endereco, write_data, read_data;

  logic        p_req0, p_req1;
  logic        p_ack0, p_ack1, p_mem_read, p_mem_write, p_busy;
  logic [31:0] p_rdata0, p_rdata1, p_endereco, p_write_data, p_read_data;

  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
    .write_data(write_data), .read_data(read_data), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .req0(p_req0), .we0(1'b0), .addr0(32'd1), .wdata0(32'd0), .ack0(p_ack0), .rdata0(p_rdata0),
    .req1(p_req1), .we1(1'b0), .addr1(32'd2), .wdata1(32'd0), .ack1(p_ack1), .rdata1(p_rdata1),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .endereco(p_endereco),
    .write_data(p_write_data), .read_data(p_read_data), .busy(p_busy)
  );

  // data_memory model: 32 words, combinational read, word 0 preloaded with 0xFFF.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h0000_0FFF;
    end else if (mem_write) begin
      mem[endereco[4:0]] <= write_data;
    end
  end
  assign read_data   = mem[endereco[4:0]];
  assign p_read_data = 32'hA5A5_0000 | p_endereco;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on a single port, checking ACCESS, RESP and the following IDLE cycle.
  task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rexp);
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    tick();
    check("access_mem_write", mem_write, we);
    check("access_mem_read", mem_read, !we);
    check("access_addr", endereco, addr);
    if (we) check("access_wdata", write_data, wdata);
    check("access_busy", busy, 1);
    check("access_no_ack", ack0 | ack1, 0);
    tick();
    check("resp_ack_sel", port ? ack1 : ack0, 1);
    check("resp_ack_other", port ? ack0 : ack1, 0);
    check("resp_strobes", mem_write | mem_read, 0);
    if (!we) check("resp_rdata", port ? rdata1 : rdata0, rexp);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("idle_ack_clear", ack0 | ack1, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_clear = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    p_req0 = 0; p_req1 = 0;
    tick();
    tick();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", mem_read | mem_write, 0);
    check("rst_endereco", endereco, 0);
    check("rst_write_data", write_data, 0);
    rst_n = 1'b1; mem_clear = 1'b0;
    tick();

    // Port 0 write then read back.
    txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0);
    check("mem5_written", mem[5], 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF);

    // Port 1 reads the preloaded word; port 0 read data must stay put.
    txn(1'b1, 1'b0, 32'd0, 32'd0, 32'h0000_0FFF);
    check("rdata0_unchanged", rdata0, 32'hDEAD_BEEF);

    // Both ports requesting continuously; fixed-priority instance sees the same pattern.
    req0 = 1; we0 = 1; addr0 = 32'd3; wdata0 = 32'h11;
    req1 = 1; we1 = 1; addr1 = 32'd3; wdata1 = 32'h22;
    p_req0 = 1; p_req1 = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rr_ack0", ack0, (k == 1 || k == 7));
      check("rr_ack1", ack1, (k == 4 || k == 10));
      check("fp_ack0", p_ack0, (k % 3 == 1));
      check("fp_ack1", p_ack1, 0);
      if (k == 1) check("fp_rdata0", p_rdata0, 32'hA5A5_0001);
    end
    req0 = 0; req1 = 0; p_req0 = 0; p_req1 = 0;
    tick();
    check("rr_mem3_last", mem[3], 32'h22);
    txn(1'b0, 1'b0, 32'd3, 32'd0, 32'h22);

    // Reset lands during the ACCESS cycle of a write.
    req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = 32'hCAFE;
    tick();
    check("pre_rst_mem_write", mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("rst_gates_mem_write", mem_write, 0);
    tick();
    req0 = 0;
    check("rst_mid_ack0", ack0, 0);
    check("rst_mid_rdata0", rdata0, 0);
    check("rst_mid_rdata1", rdata1, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_mem7", mem[7], 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ack0", ack0, 0);
    txn(1'b1, 1'b0, 32'd7, 32'd0, 32'd0);

    // Inputs changed and req dropped after the grant must not disturb the transaction.
    req1 = 1; we1 = 1; addr1 = 32'd9; wdata1 = 32'h5A5A;
    tick();
    req1 = 0; we1 = 0; addr1 = 32'd10; wdata1 = 32'h1234;
    #1;
    check("late_addr", endereco, 32'd9);
    check("late_wdata", write_data, 32'h5A5A);
    check("late_mem_write", mem_write, 1);
    tick();
    check("late_ack1", ack1, 1);
    check("late_ack0", ack0, 0);
    tick();
    check("late_mem9", mem[9], 32'h5A5A);
    check("late_mem10", mem[10], 32'd0);
    check("late_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single data_memory instance between requester 0 (CPU load/store unit) and requester 1 (program loader / debug port).
- Accepts independent req/ack handshakes and selects one requester per transaction (round-robin or fixed priority).
- Drives the memory's mem_read, mem_write, endereco and write_data for exactly one cycle per transaction, then returns registered read data with a one-cycle ack.
- Sits between the requesters and data_memory; data_memory itself is unchanged.

Parameters:
- ADDR_W, 32, address width of requester and memory address ports.
- DATA_W, 32, data width of write/read paths.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write, 0 = read); valid while req0.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 transaction complete, one-cycle pulse.
- rdata0  out  DATA_W  port 0 read data, valid while ack0.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_read  out  1  to data_memory mem_read.
- mem_write  out  1  to data_memory mem_write.
- endereco  out  ADDR_W  to data_memory address.
- write_data  out  DATA_W  to data_memory write_data.
- read_data  in  DATA_W  from data_memory (combinational read).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: every output and register is updated at the rising edge while rst_n = 0.
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; latched address/data/we = 0; busy = 0.
- mem_read and mem_write are combinationally ANDed with rst_n. No memory write may commit at an edge where rst_n = 0, including reset asserted mid-ACCESS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: FIXED_PRIO = 1 grants port 0; FIXED_PRIO = 0 grants the port that is not last_grant.
  - On grant: latch sel, we, addr and wdata from the granted port; update last_grant := sel; go to ACCESS.
- ACCESS, one cycle:
  - Drive endereco = latched addr and write_data = latched wdata.
  - mem_write = latched we; mem_read = not latched we.
  - At the closing edge, a write commits in memory. For a read, read_data is captured into rdata of the selected port; the other port's rdata is unchanged.
  - Go to RESP.
- RESP, one cycle: ack of the selected port = 1 (registered); the other ack = 0. Go to IDLE.
  - The requester drops req in the cycle after ack.
  - A req still high in the first IDLE cycle after RESP is treated as a new request; the requester is responsible for dropping it.
- Memory outputs outside ACCESS: mem_read = mem_write = 0; endereco and write_data hold their latched values.
- Latency: req sampled high at edge t in IDLE → ACCESS during cycle t+1 → ack high during cycle t+2. Maximum throughput is one transaction per 3 cycles.
- Input changes: we/addr/wdata changes after the grant edge have no effect on the current transaction. A req drop by the granted port after grant does not abort it; ack is still issued.
- Starvation bound (round-robin): with both ports continuously requesting, grants alternate 0,1,0,1…; no port waits more than 6 cycles after sampling.
- Address: passed through at full ADDR_W without modification; data_memory uses bits [4:0] only. No range checking.
- Reset mid-transaction: the transaction is dropped, with no ack and no write. rdata registers clear to 0.

Test Plan:
- Single write then read, port 0: req0, we0 = 1, addr0 = 5, wdata0 = 0xDEADBEEF → mem_write high exactly 1 cycle with endereco = 5, ack0 two cycles after grant edge; then read addr0 = 5 → rdata0 = 0xDEADBEEF with ack0.
- Preloaded word: port 1 reads addr 0 after reset → rdata1 = 0x00000FFF, ack1 pulses once, ack0 stays 0.
- Simultaneous requests, FIXED_PRIO = 0: both req high continuously, port 0 writes 0x11 to addr 3, port 1 writes 0x22 to addr 3 → grant order 0,1,0,1; final read of addr 3 returns whichever port was granted last; ack pulses never overlap.
- FIXED_PRIO = 1 with both req held high for 12 cycles → only port 0 acked, 4 acks at cycles 2, 5, 8, 11 relative to first sample.
- Reset mid-ACCESS: port 0 write 0xCAFE to addr 7, rst_n = 0 during the ACCESS cycle → mem_write = 0 at that edge, no ack0, addr 7 still reads 0 after reset.
- Input change after grant: port 1 changes addr1 from 9 to 10 and we1 from 1 to 0 in the ACCESS cycle → write of the original wdata1 lands at addr 9, addr 10 unchanged, ack1 issued.
